// File: rtl/nand_xor_sequencer_pkg.sv
// Shared types and constants for the NAND-cell XOR/XNOR sequencer.
package nand_xor_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    N1   = 3'd1,
    N2   = 3'd2,
    N3   = 3'd3,
    N4   = 3'd4,
    N5   = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam int unsigned XOR_OPS_PER_BIT  = 4;
  localparam int unsigned XNOR_OPS_PER_BIT = 5;

endpackage

// File: rtl/nand_xor_sequencer_if.sv
// Request/result bundle between a requester and the NAND XOR/XNOR sequencer.
interface nand_xor_sequencer_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;

  modport master (
    output start, mode, a, b,
    input  busy, done, s
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, s
  );

endinterface

// File: rtl/nand_xor_sequencer_nand_cell.sv
// Single 2-input NAND cell; the one shared resource the sequencer schedules.
module nand_cell (
  input  logic x,
  input  logic y,
  output logic z
);

  assign z = ~(x & y);

endmodule

// File: rtl/nand_xor_sequencer.sv
// Bit-serial XOR/XNOR built from one time-multiplexed NAND cell, LSB first,
// with a start/busy/done handshake.
module nand_xor_sequencer
  import nand_xor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  nand_xor_sequencer_if.slave  bus
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic             mode_lat;
  logic [IW-1:0]    i;
  logic             r1;
  logic             r2;
  logic             r3;
  logic             r4;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] s_q;
  logic             busy_q;
  logic             done_q;

  logic             x_bit;
  logic             y_bit;
  logic             cx;
  logic             cy;
  logic             cz;
  logic [WIDTH-1:0] res_upd;
  logic             last_bit;

  assign x_bit    = a_lat[i];
  assign y_bit    = b_lat[i];
  assign last_bit = (i == IW'(WIDTH - 1));

  // Operand mux: each N-state feeds the cell its step of the NAND XOR schedule.
  always_comb begin
    cx = 1'b0;
    cy = 1'b0;
    case (state)
      N1: begin cx = x_bit; cy = y_bit; end
      N2: begin cx = x_bit; cy = r1;    end
      N3: begin cx = y_bit; cy = r1;    end
      N4: begin cx = r2;    cy = r3;    end
      N5: begin cx = r4;    cy = r4;    end
      default: begin cx = 1'b0; cy = 1'b0; end
    endcase
  end

  nand_cell u_cell (
    .x (cx),
    .y (cy),
    .z (cz)
  );

  // Result with the current bit replaced, so s can capture the final bit too.
  always_comb begin
    res_upd    = res;
    res_upd[i] = cz;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_lat    <= '0;
      b_lat    <= '0;
      mode_lat <= 1'b0;
      i        <= '0;
      r1       <= 1'b0;
      r2       <= 1'b0;
      r3       <= 1'b0;
      r4       <= 1'b0;
      res      <= '0;
      s_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_lat    <= bus.a;
            b_lat    <= bus.b;
            mode_lat <= bus.mode;
            i        <= '0;
            busy_q   <= 1'b1;
            state    <= N1;
          end
        end
        N1: begin r1 <= cz; state <= N2; end
        N2: begin r2 <= cz; state <= N3; end
        N3: begin r3 <= cz; state <= N4; end
        N4, N5: begin
          if (state == N4 && mode_lat) begin
            r4    <= cz;
            state <= N5;
          end else begin
            res <= res_upd;
            if (last_bit) begin
              s_q    <= res_upd;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              i     <= i + IW'(1);
              state <= N1;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;

endmodule

// File: tb/tb_nand_xor_sequencer.sv
// Randomised self-checking bench for nand_xor_sequencer against a word-level model.
module tb_nand_xor_sequencer;
  import nand_xor_pkg::*;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  nand_xor_sequencer_if #(.WIDTH(WIDTH)) bus ();

  nand_xor_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic m);
    return m ? ~(a ^ b) : (a ^ b);
  endfunction

  // One full operation; optionally scrambles inputs every cycle and/or fires
  // ignored start requests mid-run and in the DONE cycle.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic m, input bit toggle, input bit inject);
    logic [WIDTH-1:0] exp_s;
    int               lat;
    int               n;
    bit               got;
    int               extra;
    exp_s = model(a, b, m);
    lat   = int'(m ? XNOR_OPS_PER_BIT : XOR_OPS_PER_BIT) * int'(WIDTH);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.mode = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, " busy_at_accept"}, 32'(bus.busy), 32'd1);
    n = 0; got = 1'b0;
    while (n < 200 && !got) begin
      if (toggle) begin
        bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.mode = ~bus.mode;
      end
      if (inject) begin
        bus.start = (n == 9);
        if (n == 9) begin bus.a = '1; bus.b = '1; end
      end
      @(posedge clk); #1;
      n++;
      if (bus.done) got = 1'b1;
      else if (!bus.busy) begin
        check({tag, " busy_dropped_early"}, 32'(n), 32'(lat));
        n = 200;
      end
    end
    bus.start = 1'b0;
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " s"}, 32'(bus.s), 32'(exp_s));
    if (inject) begin
      bus.start = 1'b1; bus.a = '1; bus.b = '1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, " done_after"}, 32'(bus.done), 32'd0);
    if (inject) begin
      extra = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (bus.busy || bus.done) extra++;
      end
      check({tag, " no_queued_op"}, 32'(extra), 32'd0);
      check({tag, " s_held"}, 32'(bus.s), 32'(exp_s));
    end
  endtask

  initial begin
    int stray;
    n_tests = 0; n_fail = 0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_s",    32'(bus.s),    32'd0);
    #22 reset = 1'b0;

    run_op("xor_basic",  8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
    run_op("xnor_basic", 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0);
    run_op("xor_ff_ff",  8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("xnor_00_ff", 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op("xnor_00_00", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("busy_start", 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a run.
    run_op("pre_abort",  8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h77; bus.mode = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_s",    32'(bus.s),    32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    stray = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) stray++;
    end
    check("abort_no_done", 32'(stray), 32'd0);
    run_op("post_abort", 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);

    // Random operands with inputs scrambled during each run.
    for (int t = 0; t < 20; t++) begin
      run_op($sformatf("rand%0d", t), WIDTH'($urandom), WIDTH'($urandom),
             1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
